inst_fetch: RTL and testbench

- Instruction-fetch front end for the MIPS 5-stage pipelined CPU; produces the instruction stream that the decode controller consumes.
- Consumes the controller's PC-change result, delivered as a resolved redirect from ID/EX.
- Talks to instruction memory over a req/ack handshake and buffers fetched words in a small queue.
- Presents {pc, pc+4, inst} to ID with a valid/ready handshake.

---
 rtl/inst_fetch.sv | 180 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: imem req/ack, small fetch queue, redirect flush/drop handling.
// Optional INST_FETCH_STAT_EN macro adds saturating stat_fetched/stat_dropped counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [31:0]                  id_inst,
  output logic [31:0]                  id_pc,
  output logic [31:0]                  id_pc_next,
  output logic [$clog2(QUEUE_DEPTH):0] q_count
`ifdef INST_FETCH_STAT_EN
  ,
  output logic [31:0]                  stat_fetched,
  output logic [31:0]                  stat_dropped
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_reg;
  logic [31:0]     fetch_pc_reg;
  logic            req_reg;
  logic [31:0]     addr_reg;
  logic [AW-1:0]   head_reg;
  logic [AW-1:0]   tail_reg;
  logic [AW:0]     count_reg;

  logic            push;
  logic            pop;
  logic [AW:0]     count_after;
  logic [31:0]     pc_plus4;
  logic [31:0]     redirect_target;
  logic            issue_idle;
  logic            issue_wait;
  logic            unused_bits;

  logic [QUEUE_DEPTH-1:0][31:0] q_pc;
  logic [QUEUE_DEPTH-1:0][31:0] q_inst;

  assign unused_bits     = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_plus4        = fetch_pc_reg + 32'd4;

  // A redirect suppresses both the push and the pop: the flush wins.
  assign id_valid    = (count_reg != '0) && en;
  assign push        = (state_reg == WAIT) && imem_ack && !redirect;
  assign pop         = id_valid && id_ready && !redirect;
  assign count_after = count_reg + (AW+1)'(push) - (AW+1)'(pop);

  // Only one request is ever outstanding, so issuing against the post-push count
  // (or the idle count) guarantees the returning word always has a slot.
  assign issue_idle  = en && !redirect && (count_reg < DEPTH_C);
  assign issue_wait  = en && !redirect && (count_after < DEPTH_C);

  assign imem_req    = req_reg;
  assign imem_addr   = addr_reg;
  assign q_count     = count_reg;
  assign id_pc       = q_pc[head_reg];
  assign id_inst     = q_inst[head_reg];
  assign id_pc_next  = id_pc + 32'd4;

  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc_reg   <= '0;
        inst_reg <= '0;
      end else if (push && (tail_reg == AW'(gi))) begin
        pc_reg   <= fetch_pc_reg;
        inst_reg <= imem_rdata;
      end
    end

    assign q_pc[gi]   = pc_reg;
    assign q_inst[gi] = inst_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_reg      <= 1'b0;
      addr_reg     <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      if (redirect) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + 1'b1;
        if (pop)  head_reg <= head_reg + 1'b1;
        count_reg <= count_after;
      end

      case (state_reg)
        IDLE: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_target;
          end else if (issue_idle) begin
            state_reg <= WAIT;
            req_reg   <= 1'b1;
            addr_reg  <= fetch_pc_reg;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_target;
            if (imem_ack) begin
              state_reg <= IDLE;
              req_reg   <= 1'b0;
            end else begin
              // Keep the old request on the bus until memory answers it.
              state_reg <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc_reg <= pc_plus4;
            if (issue_wait) begin
              addr_reg <= pc_plus4;
            end else begin
              state_reg <= IDLE;
              req_reg   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect) fetch_pc_reg <= redirect_target;
          if (imem_ack) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

`ifdef INST_FETCH_STAT_EN
  logic        drop_ack;
  logic [32:0] fetched_sum;
  logic [32:0] dropped_sum;

  // Dropped = stale/discarded acks plus whatever a redirect flushes out of the queue.
  assign drop_ack    = imem_ack && (((state_reg == WAIT) && redirect) || (state_reg == DROP));
  assign fetched_sum = {1'b0, stat_fetched} + 33'(push);
  assign dropped_sum = {1'b0, stat_dropped} + 33'(drop_ack) + (redirect ? 33'(count_reg) : 33'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      stat_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
      stat_dropped <= dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a model fetch address/queue is updated on each ack and
// popped as ID consumes; a second instance exercises RESET_PC address wrap.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic [1:0]  q_count;

  logic        imem_req_b;
  logic [31:0] imem_addr_b;
  logic        imem_ack_b;
  logic [31:0] imem_rdata_b;
  logic        id_valid_b;
  logic [31:0] id_inst_b;
  logic [31:0] id_pc_b;
  logic [31:0] id_pc_next_b;
  logic [1:0]  q_count_b;
`ifdef INST_FETCH_STAT_EN
  logic [31:0] stat_fetched, stat_dropped, stat_fetched_b, stat_dropped_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_pops = 0;
  int n_pops_b = 0;
  int mem_lat = 0;
  int wait_cnt;
  int ack_b_cnt;

  entry_t      sb_q[$];
  entry_t      sb_b[$];
  entry_t      e;
  entry_t      eb;
  logic [31:0] exp_addr;
  logic [31:0] exp_b;
  logic        stale;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory with programmable ack latency (0 = ack in the request cycle).
  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = mem_word(imem_addr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Second memory answers only the first three requests.
  assign imem_ack_b   = imem_req_b && (ack_b_cnt < 3);
  assign imem_rdata_b = mem_word(imem_addr_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_b_cnt <= 0;
    else if (imem_ack_b) ack_b_cnt <= ack_b_cnt + 1;
  end

  inst_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_next(id_pc_next), .q_count(q_count)
`ifdef INST_FETCH_STAT_EN
    , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped)
`endif
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b),
    .id_valid(id_valid_b), .id_ready(1'b1), .id_inst(id_inst_b), .id_pc(id_pc_b),
    .id_pc_next(id_pc_next_b), .q_count(q_count_b)
`ifdef INST_FETCH_STAT_EN
    , .stat_fetched(stat_fetched_b), .stat_dropped(stat_dropped_b)
`endif
  );

  // Scoreboard for the main instance: push on accepted ack, pop on ID handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_addr = 32'h0;
        stale = 1'b0;
      end else begin
        check_val("q_count", 32'(q_count), 32'(sb_q.size()));
        check_val("id_valid", 32'(id_valid), 32'((sb_q.size() != 0) && en));
        if (redirect) begin
          sb_q.delete();
        end else if (en && id_ready && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_val("id_pc", id_pc, e.pc);
          check_val("id_inst", id_inst, e.inst);
          check_val("id_pc_next", id_pc_next, e.pc + 32'd4);
          n_pops++;
        end
        if (imem_ack) begin
          if (redirect || stale) begin
            stale = 1'b0;
          end else begin
            check_val("imem_addr", imem_addr, exp_addr);
            sb_q.push_back({exp_addr, mem_word(exp_addr)});
            exp_addr = exp_addr + 32'd4;
          end
        end else if (redirect && imem_req) begin
          stale = 1'b1;
        end
        if (redirect) exp_addr = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Scoreboard for the wrap instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_b.delete();
        exp_b = 32'hFFFF_FFF8;
      end else begin
        check_val("b_id_valid", 32'(id_valid_b), 32'(sb_b.size() != 0));
        if (sb_b.size() != 0) begin
          eb = sb_b.pop_front();
          check_val("b_id_pc", id_pc_b, eb.pc);
          check_val("b_id_inst", id_inst_b, eb.inst);
          check_val("b_id_pc_next", id_pc_next_b, eb.pc + 32'd4);
          n_pops_b++;
        end
        if (imem_ack_b) begin
          check_val("b_imem_addr", imem_addr_b, exp_b);
          sb_b.push_back({exp_b, mem_word(exp_b)});
          exp_b = exp_b + 32'd4;
        end
      end
    end
  end

  initial begin
    logic        ok;
    logic [31:0] old_addr;
    int          p0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_imem_req", 32'(imem_req), 32'd0);
    check_val("rst_imem_addr", imem_addr, 32'h0);
    check_val("rst_id_valid", 32'(id_valid), 32'd0);
    check_val("rst_id_inst", id_inst, 32'h0);
    check_val("rst_id_pc", id_pc, 32'h0);
    check_val("rst_id_pc_next", id_pc_next, 32'h4);
    check_val("rst_q_count", 32'(q_count), 32'd0);
    check_val("rst_b_imem_addr", imem_addr_b, 32'hFFFF_FFF8);

    // Zero-wait memory, ID always ready: one instruction per cycle.
    en = 1'b1; id_ready = 1'b1; mem_lat = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    p0 = n_pops;
    repeat (6) @(posedge clk);
    #1;
    check_val("t1_throughput", 32'(n_pops - p0), 32'd6);

    // ID stalls: queue fills, request stops; then drain and resume.
    id_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("t2_q_full", 32'(q_count), 32'd2);
    check_val("t2_req_off", 32'(imem_req), 32'd0);
    id_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 3 && !ok; k++) begin
      @(posedge clk); #1;
      ok = imem_req;
    end
    check_val("t2_resume", 32'(ok), 32'd1);
    repeat (6) @(posedge clk);
    #1;

    // 3-cycle memory; redirect in the cycle after a fresh request.
    mem_lat = 3;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = imem_req && (wait_cnt == 0);
    end
    check_val("t3_req_seen", 32'(ok), 32'd1);
    old_addr = imem_addr;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #1;
    redirect = 1'b0;
    check_val("t3_drop_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 6 && imem_req && !imem_ack; k++) begin
      check_val("t3_hold_addr", imem_addr, old_addr);
      @(posedge clk); #1;
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = id_valid;
    end
    check_val("t3_valid_seen", 32'(ok), 32'd1);
    check_val("t3_first_pc", id_pc, 32'h0000_0100);

    // Redirect coinciding with an ack: data discarded, fetch resumes at aligned target.
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = imem_ack;
    end
    check_val("t4_ack_seen", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(posedge clk); #1;
    redirect = 1'b0;
    check_val("t4_q_empty", 32'(q_count), 32'd0);
    check_val("t4_req_off", 32'(imem_req), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 5 && !ok; k++) begin
      @(posedge clk); #1;
      ok = imem_req;
    end
    check_val("t4_req_seen", 32'(ok), 32'd1);
    check_val("t4_new_addr", imem_addr, 32'h0000_0200);

    // Freeze with one entry queued and one request outstanding.
    id_ready = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = (q_count == 2'd1) && imem_req;
    end
    check_val("t5_setup", 32'(ok), 32'd1);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("t5_q_count", 32'(q_count), 32'd2);
    check_val("t5_req_off", 32'(imem_req), 32'd0);
    check_val("t5_valid_off", 32'(id_valid), 32'd0);
    en = 1'b1; id_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Wrap instance: three fetches from FFFFFFF8 through 00000000.
    check_val("b_pops", 32'(n_pops_b), 32'd3);
`ifdef INST_FETCH_STAT_EN
    check_val("b_stat_fetched", stat_fetched_b, 32'd3);
    check_val("b_stat_dropped", stat_dropped_b, 32'd0);
`endif

    // Reset while a request is outstanding.
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      ok = imem_req;
    end
    check_val("t6_req_seen", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_req_drop", 32'(imem_req), 32'd0);
    check_val("t6_q_count", 32'(q_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_lat = 0;
    repeat (8) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
